// File: rtl/des_decrypt_iter_if.sv
// Handshake bundle for the iterative DES core: block/key in, result out.
interface des_decrypt_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] din;
    logic [63:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] dout;

    // Producer/consumer side that feeds blocks and drains results.
    modport master (
        output in_valid, din, key, out_ready,
        input  in_ready, out_valid, dout
    );

    // The DES core itself.
    modport slave (
        input  in_valid, din, key, out_ready,
        output in_ready, out_valid, dout
    );
endinterface

// File: rtl/des_decrypt_iter.sv
// Iterative DES core: one Feistel round per clock, 16 rounds per block.
// DECRYPT=1 walks the key schedule backwards (K16..K1) by rotating C/D right,
// DECRYPT=0 walks it forwards (K1..K16) for loopback self-test.
module des_decrypt_iter #(
    parameter int DECRYPT = 1
) (
    input  logic clk,
    input  logic rst,
    des_decrypt_iter_if.slave bus
);
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    // One word per S-box row, 16 nibbles, column 0 in the top nibble.
    localparam logic [63:0] SBOX_T [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

    // Table positions are 1-based from the MSB (DES bit 1 = vector MSB).
    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y = {y[62:0], x[6'(64 - IP_T[i])]};
        return y;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y = {y[62:0], x[6'(64 - FP_T[i])]};
        return y;
    endfunction

    function automatic logic [47:0] perm_e(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y = {y[46:0], x[5'(32 - E_T[i])]};
        return y;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y = {y[30:0], x[5'(32 - P_T[i])]};
        return y;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y = {y[54:0], x[6'(64 - PC1_T[i])]};
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y = {y[46:0], x[6'(56 - PC2_T[i])]};
        return y;
    endfunction

    // Row = outer bits, column = inner four bits of the 6-bit group.
    function automatic logic [3:0] sbox(input logic [2:0] box, input logic [5:0] six);
        logic [63:0] w;
        w = SBOX_T[{box, six[5], six[0]}];
        w = w << {six[4:1], 2'b00};
        return w[63:60];
    endfunction

    // S-box layer followed by P.
    function automatic logic [31:0] sp(input logic [47:0] x);
        logic [47:0] t;
        logic [31:0] s;
        t = x;
        s = '0;
        for (int j = 0; j < 8; j++) begin
            s = {s[27:0], sbox(3'(j), t[47:42])};
            t = t << 6;
        end
        return perm_p(s);
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t      state;
    logic [31:0] l_q, r_q;
    logic [27:0] c_q, d_q;
    logic [3:0]  cnt;
    logic        out_valid_q;
    logic [63:0] dout_q;
    logic        accept;
    logic [27:0] c_use, d_use, c_nxt, d_nxt;
    logic        sh_two;
    logic [31:0] r_nxt;

    assign bus.in_ready  = (state == IDLE) || (state == DONE && bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign accept        = bus.in_valid && bus.in_ready;

    // Round datapath: pick this round's C/D, form the subkey, apply f.
    always_comb begin
        c_use  = c_q;
        d_use  = d_q;
        c_nxt  = c_q;
        d_nxt  = d_q;
        sh_two = 1'b0;
        if (DECRYPT != 0) begin
            // Right-rotate after rounds 1,8,15 by one, otherwise by two.
            sh_two = !(cnt == 4'd0 || cnt == 4'd7 || cnt == 4'd14);
            c_nxt  = rotr(c_q, sh_two);
            d_nxt  = rotr(d_q, sh_two);
        end else begin
            // Left-rotate before rounds 1,2,9,16 by one, otherwise by two.
            sh_two = !(cnt == 4'd0 || cnt == 4'd1 || cnt == 4'd8 || cnt == 4'd15);
            c_use  = rotl(c_q, sh_two);
            d_use  = rotl(d_q, sh_two);
            c_nxt  = c_use;
            d_nxt  = d_use;
        end
        r_nxt = l_q ^ sp(perm_e(r_q) ^ perm_pc2({c_use, d_use}));
    end

    // Control FSM and round registers; accept takes priority in IDLE and DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            cnt         <= '0;
        end else if (accept) begin
            {l_q, r_q}  <= perm_ip(bus.din);
            {c_q, d_q}  <= perm_pc1(bus.key);
            cnt         <= '0;
            state       <= ROUND;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ROUND: begin
                    l_q <= r_q;
                    r_q <= r_nxt;
                    c_q <= c_nxt;
                    d_q <= d_nxt;
                    if (cnt == 4'd15) begin
                        // Last round: emit the swapped pre-output through FP.
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        dout_q      <= perm_fp({r_nxt, r_q});
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/des_decrypt_iter.md
DES_DECRYPT_ITER -- requirements
Module: des_decrypt_iter

Interface
REQ-001 Parameter: DECRYPT, default 1, 1 = decryption subkey order K16..K1, 0 = encryption order K1..K16 (used for loopback self-test).
REQ-002 CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  din/key valid.
REQ-005 in_ready  output  1  block accepts din/key this cycle.
REQ-006 din  input  64  input block; din[63] = DES bit 1, din[0] = DES bit 64.
REQ-007 key  input  64  DES key, same bit order; parity bits key[56], key[48], ..., key[0] ignored.
REQ-008 out_valid  output  1  dout holds a completed result.
REQ-009 out_ready  input  1  consumer takes dout this cycle.
REQ-010 dout  output  64  result block, same bit order as din.

Function
REQ-011 The block SHALL implement FIPS 46-3 DES with one Feistel round per clock: IP, E expansion, 8 S-boxes, P permutation, PC-1, PC-2, FP.
REQ-012 The block SHALL have states IDLE, ROUND and DONE.
REQ-013 in_ready SHALL equal (state==IDLE) OR (state==DONE AND out_ready); there is a combinational path from out_ready to in_ready.
REQ-014 Accept occurs on an edge with in_valid AND in_ready.
  - {L,R} <= IP(din); {C,D} <= PC-1(key); round counter <= 0; state <= ROUND.
  - din and key are sampled only at accept and may change afterwards.
REQ-015 In ROUND, each edge SHALL compute L <= R and R <= L XOR SP(E(R) XOR PC-2(C,D)), then advance the counter.
REQ-016 Key schedule with DECRYPT=1:
  - round 1 uses PC-2 of the unshifted {C,D}.
  - after rounds 1..15, C and D each rotate right by 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 respectively.
REQ-017 Key schedule with DECRYPT=0:
  - C and D rotate left by 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 before rounds 1..16.
  - this shift is combinational, ahead of PC-2 in the same cycle.
REQ-018 After the 16th round edge (counter==15), state SHALL go to DONE, out_valid SHALL be 1 and dout SHALL equal FP({R16,L16}).
  - This is the swapped pre-output.
  - Latency: accept at edge k gives out_valid high from edge k+16.
REQ-019 In DONE, dout and out_valid SHALL hold stable until an edge with out_ready=1.
  - On that edge, with no accept: state <= IDLE, out_valid <= 0.
  - dout keeps its last value.
REQ-020 Simultaneous out_ready and in_valid in DONE SHALL complete the output and accept the new block on the same edge, going straight to ROUND with no idle cycle (back-to-back throughput: one block per 17 cycles).
REQ-021 in_valid in ROUND SHALL be ignored (in_ready=0); no input is lost or overwritten.
REQ-022 out_ready while out_valid=0 SHALL have no effect.
REQ-023 The round counter SHALL be 4 bits and SHALL not wrap in normal operation; it is reset to 0 on every accept.

Reset
REQ-024 When RST is high, asynchronously:
  - state = IDLE; out_valid = 0; dout = 0;
  - L, R, C, D, counter = 0;
  - in_ready = 1 once RST is released.
REQ-025 RST asserted mid-ROUND or in DONE SHALL abort the operation with no output produced; the first accept after release SHALL behave as after power-up.

Verification
REQ-026 DECRYPT=1, key=133457799BBCDFF1, din=85E813540F0AB405, out_ready=1 -> out_valid exactly 16 edges after accept, dout=0123456789ABCDEF.
REQ-027 DECRYPT=1, key=0000000000000000, din=8CA64DE9C1B123A7 -> dout=0000000000000000; repeat with the parity bits of the key flipped -> same result.
REQ-028 DECRYPT=0, key=133457799BBCDFF1, din=0123456789ABCDEF -> dout=85E813540F0AB405; also run 1000 random key/block pairs as encrypt then decrypt loopback -> original block returned.
REQ-029 out_ready held 0 for 10 cycles after out_valid -> dout stable and in_ready=0 throughout; raise out_ready together with in_valid -> new block accepted that same edge, next out_valid 16 edges later.
REQ-030 RST pulsed at round 7 -> out_valid=0 and dout=0 immediately; a fresh accept then yields the correct vector from REQ-026 with no corruption.
REQ-031 in_valid toggled and din changed during ROUND -> result unaffected, and no extra accept appears in the in_valid AND in_ready count.
